// File: rtl/cmp_result_fifo.sv
// cmp_result_fifo: registered elastic FIFO for compare results, NUM_SLOTS deep, any depth >= 2
module cmp_result_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);
  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);
  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic live, push, pop;
  // handshake flags derive only from registered state; live keeps ins_ready low until the first edge after reset
  always_comb begin
    outs_valid = count != '0;
    ins_ready  = live && count != FULL;
    push       = ins_valid && ins_ready;
    pop        = outs_valid && outs_ready;
    outs       = mem[head];
  end
  // pointers, occupancy and the post-reset ready flag; tokens vanish the moment rst falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      live  <= 1'b0;
    end else begin
      live  <= 1'b1;
      head  <= pop ? (head == LAST ? '0 : head + PW'(1)) : head;
      tail  <= push ? (tail == LAST ? '0 : tail + PW'(1)) : tail;
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
    end
  end
  // payload storage carries no reset; only valid entries are ever observed
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= ins;
  end
endmodule
